// File: rtl/pw_requant_stage.sv
// Per-channel int32 -> int8 requantization: bias add, scale, round/shift/zero-point/clamp, output FIFO.
// Optional fused ReLU in the quantized domain when PW_REQUANT_RELU_EN is defined.
module pw_requant_stage #(
  parameter int MAX_CHANNELS = 1024,
  parameter int CH_AW        = 10,
  parameter int FIFO_DEPTH   = 8,
  localparam int FAW         = $clog2(FIFO_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CH_AW-1:0] num_output_channels,
  input  logic             start_layer,
  input  logic             cfg_we,
  input  logic [CH_AW-1:0] cfg_addr,
  input  logic [31:0]      cfg_bias,
  input  logic [15:0]      cfg_mult,
  input  logic [4:0]       cfg_shift,
  input  logic [7:0]       out_zero_point,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic [CH_AW-1:0] out_channel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             layer_done,
  output logic             overflow,
  output logic [FAW:0]     fifo_count
);

  logic [31:0] r_bias_mem  [MAX_CHANNELS];
  logic [15:0] r_mult_mem  [MAX_CHANNELS];
  logic [4:0]  r_shift_mem [MAX_CHANNELS];

  logic [CH_AW-1:0] r_ch, w_nch, w_tag;
  logic             w_last;
  logic [2:0]       r_vld_pipe;

  logic signed [31:0] r_s1;
  logic [15:0]        r_mult1;
  logic [4:0]         r_shift1, r_shift2;
  logic [CH_AW-1:0]   r_ch1, r_ch2, r_ch3;
  logic               r_last1, r_last2, r_last3;
  logic signed [47:0] r_p;
  logic [7:0]         r_q3;

  logic signed [32:0] w_sum;
  logic signed [31:0] w_s1;
  logic signed [47:0] w_prod;
  logic signed [48:0] w_p49, w_half, w_r, w_z;
  logic [7:0]         w_q;

  // Parameter memory: asynchronous read, so a same-cycle write is seen only next cycle.
  always_ff @(posedge clock) begin
    if (cfg_we) begin
      r_bias_mem[cfg_addr]  <= cfg_bias;
      r_mult_mem[cfg_addr]  <= cfg_mult;
      r_shift_mem[cfg_addr] <= cfg_shift;
    end
  end

  always_comb begin
    w_nch  = (num_output_channels == '0) ? CH_AW'(1) : num_output_channels;
    w_tag  = start_layer ? '0 : r_ch;
    w_last = (w_tag == w_nch - CH_AW'(1));
    w_sum  = $signed({in_data[31], in_data}) +
             $signed({r_bias_mem[w_tag][31], r_bias_mem[w_tag]});
    if (w_sum > 33'sh0_7FFF_FFFF)       w_s1 = 32'sh7FFF_FFFF;
    else if (w_sum < -33'sh0_8000_0000) w_s1 = -32'sh8000_0000;
    else                                w_s1 = w_sum[31:0];
  end

  // Product of |s1| < 2^31 and mult < 2^16 always fits in 48 signed bits.
  assign w_prod = $signed({{16{r_s1[31]}}, r_s1}) * $signed({32'd0, r_mult1});

  always_comb begin
    w_p49  = {r_p[47], r_p};
    w_half = (r_shift2 == 5'd0) ? 49'sd0 : (49'sd1 <<< (r_shift2 - 5'd1));
    w_r    = (w_p49 + w_half) >>> r_shift2;
    w_z    = w_r + $signed({{41{out_zero_point[7]}}, out_zero_point});
    if (w_z > 49'sd127)       w_q = 8'h7F;
    else if (w_z < -49'sd128) w_q = 8'h80;
    else                      w_q = w_z[7:0];
`ifdef PW_REQUANT_RELU_EN
    if ($signed(w_q) < $signed(out_zero_point)) w_q = out_zero_point;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_ch       <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], in_valid};
      if (in_valid)         r_ch <= w_last ? '0 : w_tag + CH_AW'(1);
      else if (start_layer) r_ch <= '0;
    end
  end

  always_ff @(posedge clock) begin
    r_s1     <= w_s1;
    r_mult1  <= r_mult_mem[w_tag];
    r_shift1 <= r_shift_mem[w_tag];
    r_ch1    <= w_tag;
    r_last1  <= w_last;
    r_p      <= w_prod;
    r_shift2 <= r_shift1;
    r_ch2    <= r_ch1;
    r_last2  <= r_last1;
    r_q3     <= w_q;
    r_ch3    <= r_ch2;
    r_last3  <= r_last2;
  end

  logic [7:0]       r_fifo_data [FIFO_DEPTH];
  logic [CH_AW-1:0] r_fifo_ch   [FIFO_DEPTH];
  logic [FAW:0]     r_wptr, r_rptr;
  logic             r_done, r_ovf;
  logic             w_full, w_pop, w_push;

  assign fifo_count = r_wptr - r_rptr;
  assign w_full     = (fifo_count == (FAW+1)'(FIFO_DEPTH));
  assign out_valid  = (fifo_count != '0);
  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_vld_pipe[2] & (~w_full | w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_ch[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr[FAW-1:0]] <= r_q3;
        r_fifo_ch[r_wptr[FAW-1:0]]   <= r_ch3;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      // Done fires on the last result even when it was dropped.
      r_done <= r_vld_pipe[2] & r_last3;
      if (r_vld_pipe[2] & ~w_push) r_ovf <= 1'b1;
      else if (start_layer)        r_ovf <= 1'b0;
    end
  end

  assign out_data    = r_fifo_data[r_rptr[FAW-1:0]];
  assign out_channel = r_fifo_ch[r_rptr[FAW-1:0]];
  assign layer_done  = r_done;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_pw_requant_stage.sv
// Scoreboard bench for pw_requant_stage: directed vectors with hand-computed results.
module tb_pw_requant_stage;
  localparam int CH_AW = 10;
  localparam int FD    = 8;

  logic              clock = 1'b0, reset = 1'b1;
  logic [CH_AW-1:0]  num_output_channels = '0;
  logic              start_layer = 0, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [CH_AW-1:0]  cfg_addr = '0;
  logic [31:0]       cfg_bias = '0, in_data = '0;
  logic [15:0]       cfg_mult = '0;
  logic [4:0]        cfg_shift = '0;
  logic [7:0]        out_zero_point = '0;
  logic signed [7:0] out_data;
  logic [CH_AW-1:0]  out_channel;
  logic              out_valid, layer_done, overflow;
  logic [3:0]        fifo_count;

  pw_requant_stage #(.MAX_CHANNELS(1024), .CH_AW(CH_AW), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .num_output_channels(num_output_channels),
    .start_layer(start_layer), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .out_zero_point(out_zero_point), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready), .layer_done(layer_done), .overflow(overflow),
    .fifo_count(fifo_count));

  int total = 0, bad = 0, cyc = 0;
  logic [17:0] sb_q[$];
  int          done_q[$];
  logic [17:0] mon_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is checked against the scoreboard head.
  always @(negedge clock) begin
    if (layer_done) done_q.push_back(cyc);
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got data %0d ch %0d, required no output", out_data, out_channel);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_data", out_data, $signed(mon_e[7:0]));
        chk("out_channel", out_channel, mon_e[17:8]);
      end
    end
  end

  task automatic cfg(input int a, input logic [31:0] b, input logic [15:0] m, input logic [4:0] s);
    @(negedge clock);
    cfg_we = 1; cfg_addr = CH_AW'(a); cfg_bias = b; cfg_mult = m; cfg_shift = s;
    @(negedge clock);
    cfg_we = 0;
  endtask

  task automatic start(input int n);
    @(negedge clock);
    num_output_channels = CH_AW'(n); start_layer = 1;
    @(negedge clock);
    start_layer = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic signed [7:0] ed, input int ec, input bit push);
    @(negedge clock);
    in_data = d; in_valid = 1;
    if (push) sb_q.push_back({CH_AW'(ec), ed});
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  int dc;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_channel", out_channel, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_count", fifo_count, 0);
    reset = 0;
    for (int i = 0; i < 16; i++) cfg(i, 0, 1, 0);

    // Basic requant with latency check: 200+56=256, *16384=2^22, >>15 rounded=128, -5 -> 123
    cfg(0, 56, 16384, 15);
    out_zero_point = -8'sd5; out_ready = 1;
    start(4);
    send(200, 123, 0, 1);
    idle();
    @(negedge clock); chk("lat_e1", out_valid, 0);
    @(negedge clock); chk("lat_e2", out_valid, 0);
    @(negedge clock); chk("lat_e3", out_valid, 1);
    drain();

    // Rounding half up toward +inf
    cfg(0, 0, 1, 1); cfg(1, 0, 1, 1);
    out_zero_point = 0;
    start(4);
    send(3, 2, 0, 1);
    send(-3, -1, 1, 1);
    idle(); drain();

    // Saturation: bias add, clamp low/high, negative bias saturation with shift 31
    cfg(0, 0, 1000, 0); cfg(1, 10, 1000, 0); cfg(2, 32'h8000_0000, 1, 31);
    start(4);
    send(-100000, -128, 0, 1);
    send(32'h7FFF_FFFF, 127, 1, 1);
    send(-5, -1, 2, 1);
    idle(); drain();

    // Config write colliding with stage-1 read of the same channel returns old params
    cfg(0, 100, 1, 0);
    @(negedge clock);
    num_output_channels = 4; start_layer = 1; in_valid = 1; in_data = 5;
    cfg_we = 1; cfg_addr = 0; cfg_bias = 0; cfg_mult = 1; cfg_shift = 0;
    sb_q.push_back({CH_AW'(0), 8'sd105});
    @(negedge clock);
    start_layer = 0; in_valid = 0; cfg_we = 0;
    drain();
    start(4);
    send(5, 5, 0, 1);
    idle(); drain();

    // Channel wrap and layer_done alignment
    cfg(1, 0, 1, 0); cfg(2, 0, 1, 0);
    start(3);
    done_q.delete();
    send(10, 10, 0, 1);
    send(20, 20, 1, 1);
    send(30, 30, 2, 1);
    dc = cyc + 4;
    send(40, 40, 0, 1);
    idle(); drain();
    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cycle", done_q[0], dc);

    // Zero channels treated as one: every input is channel 0
    start(0);
    send(7, 7, 0, 1);
    send(8, 8, 0, 1);
    idle(); drain();

    // Backpressure: FD+1 inputs, last one dropped
    @(negedge clock); out_ready = 0;
    start(16);
    for (int i = 0; i < FD + 1; i++) send(i + 1, 8'(i + 1), i, i < FD);
    idle();
    repeat (5) @(negedge clock);
    chk("ovf_count", fifo_count, FD);
    chk("ovf_flag", overflow, 1);
    chk("ovf_valid", out_valid, 1);
    out_ready = 1;
    drain();
    chk("ovf_sticky", overflow, 1);
    start(4);
    chk("ovf_cleared", overflow, 0);

    // Fused ReLU: -50 + (-5) = -55, or the zero point when ReLU is built in
    cfg(0, 0, 1, 0);
    out_zero_point = -8'sd5;
    start(4);
`ifdef PW_REQUANT_RELU_EN
    send(-50, -5, 0, 1);
`else
    send(-50, -55, 0, 1);
`endif
    idle(); drain();

    // Asynchronous reset mid-layer drops FIFO contents and in-flight results
    out_zero_point = 0;
    @(negedge clock); out_ready = 0;
    start(4);
    send(1, 0, 0, 0);
    send(2, 0, 0, 0);
    idle();
    repeat (4) @(negedge clock);
    chk("pre_rst_count", fifo_count, 2);
    send(3, 0, 0, 0);
    idle();
    #2 reset = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_data", out_data, 0);
    @(negedge clock); reset = 0;
    repeat (6) @(negedge clock);
    chk("post_rst_count", fifo_count, 0);
    out_ready = 1;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pw_requant_stage.md
# pw_requant_stage

Downstream stage of `pointwise_conv1x1_engine`. It takes each 32-bit accumulator result, one per output channel, and converts it to an int8 activation for the next layer. Per-channel bias, multiplier and shift come from a small config memory. The arithmetic is a 3-stage pipeline: bias add, scale multiply, then round/shift/zero-point/clamp. Results go through an output FIFO with a valid/ready handshake toward the activation writer.

## Interface
- `MAX_CHANNELS`, 1024: depth of the per-channel parameter memory.
- `CH_AW`, 10: channel index width; must equal clog2(`MAX_CHANNELS`).
- `FIFO_DEPTH`, 8: output FIFO entries (power of 2, ≥2).

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `num_output_channels` in `CH_AW`: output channels in the layer; 0 is treated as 1.
- `start_layer` in 1: single-cycle pulse; channel counter ← 0, `overflow` ← 0.
- `cfg_we` in 1: write strobe for the parameter memory.
- `cfg_addr` in `CH_AW`: channel to write.
- `cfg_bias` in 32: signed bias.
- `cfg_mult` in 16: unsigned multiplier.
- `cfg_shift` in 5: right shift, 0..31.
- `out_zero_point` in 8: signed output zero point; layer-static.
- `in_data` in 32: signed `conv_result` from the engine.
- `in_valid` in 1: `result_valid` from the engine. Always accepted; there is no backpressure upstream.
- `out_data` out 8: signed int8 result at the FIFO head.
- `out_channel` out `CH_AW`: channel index of `out_data`.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer pops the head when `out_valid` & `out_ready`.
- `layer_done` out 1: one-cycle pulse when the last channel's result is written into the FIFO.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.
- `fifo_count` out clog2(`FIFO_DEPTH`)+1: current occupancy.

## Operation
- **Channel counter `ch`.**
  - Each `in_valid` tags the input with the current `ch`, then increments `ch`.
  - When the tagged channel is `num_output_channels`−1, `ch` wraps to 0 and the tag carries a last flag.
- **Stage 1.**
  - Reads params[`ch`].
  - Computes `s1 = sat32(in_data + bias)`, a signed 33-bit sum saturated to the int32 range.
- **Stage 2.** `p = s1 × mult`, with `mult` zero-extended; 48-bit signed product.
- **Stage 3.**
  - If `shift` > 0: `r = (p + 2^(shift−1)) >>> shift`, an arithmetic shift giving round-half-up toward +∞.
  - If `shift` = 0: `r = p`.
  - Then `q = r + sext(out_zero_point)`, clamped to [−128, 127], and written into the FIFO together with its channel tag.
- **FIFO.**
  - Write when stage 3 is valid.
  - If full and not popping in the same cycle: the result is dropped, `overflow` ← 1, and `layer_done` still fires if the dropped result carried the last flag.
  - Simultaneous push and pop while full is legal and loses nothing.
- **Config writes.**
  - Written at the clock edge.
  - A stage-1 read of the same address in the same cycle returns the old value.
  - Writes during a layer are legal but unchecked by hardware.
- **`start_layer` with `in_valid` in the same cycle.** The input is tagged channel 0 and `ch` becomes 1 (or 0 if `num_output_channels` ≤ 1). Results already in flight keep their tags.
- **Reset.** Clears the pipeline valids, FIFO pointers, `ch` and `overflow`. The parameter memory is not reset.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_channel`=0.
  - `layer_done`=0, `overflow`=0, `fifo_count`=0.
- Latency:
  - Input sampled at edge E0 with `in_valid`=1.
  - FIFO write at edge E0+3.
  - `out_valid`=1 from edge E0+3 if the FIFO was empty.
  - `layer_done` is high in the cycle after E0+3.
- Throughput is one result per cycle sustained. The FIFO output is show-ahead: data is valid while `out_valid` is high.
- The pop takes effect at the edge where `out_valid` & `out_ready`.
- `fifo_count` is updated at the same edge as the push or pop.
- Reset asserted mid-layer: all outputs return to their reset values asynchronously, and in-flight results are lost.

## Configuration
- Macro `PW_REQUANT_RELU_EN`:
  - **Defined:** after clamping, `q = max(q, out_zero_point)`, which is fused ReLU in the quantized domain.
  - **Undefined:** the plain clamp to [−128, 127] only.

## Test plan
- **Basic requant.** Params ch0 = {bias 56, mult 16384, shift 15}, zp −5; `in_data` 200 → `out_data` 123, `out_channel` 0, `out_valid` 3 cycles after input.
- **Rounding.** Params {0, 1, 1}, zp 0; inputs 3 then −3 → outputs 2 then −1.
- **Saturation.** Params {0, 1000, 0}; `in_data` −100000 → −128; `in_data` 0x7FFFFFFF with bias 10 → bias saturates at int32 max, output 127.
- **Channel wrap and done.**
  - `num_output_channels` 3, 4 back-to-back inputs → channels 0, 1, 2, 0.
  - `layer_done` pulses once, aligned with the channel-2 write.
- **Backpressure and overflow.**
  - `out_ready`=0, `FIFO_DEPTH`+1 inputs → `fifo_count`=`FIFO_DEPTH`, `overflow`=1, the first 8 results are preserved in order.
  - `start_layer` clears `overflow`.
- **ReLU build** (`PW_REQUANT_RELU_EN`). Params {0, 1, 0}, zp −5, `in_data` −50 → −5. Without the macro the same stimulus gives −55.
